// File: rtl/multicycle_control_pkg.sv
// multicycle_control_pkg
// Shared definitions for the multicycle control FSM: the state encoding,
// fault codes reported on fault_o, the two supported opcode values, the
// latched instruction class and the ALUOp codes sent to the ALU decoder.
package multicycle_control_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_FETCH  = 3'd1,
        ST_DECODE = 3'd2,
        ST_EXEC   = 3'd3,
        ST_WB     = 3'd4,
        ST_HALT   = 3'd5
    } state_t;

    typedef enum logic [1:0] {
        FAULT_NONE    = 2'd0,
        FAULT_ILLEGAL = 2'd1,
        FAULT_TIMEOUT = 2'd2
    } fault_t;

    typedef enum logic [1:0] {
        CLS_NONE = 2'd0,
        CLS_R    = 2'd1,
        CLS_I    = 2'd2
    } op_class_t;

    localparam logic [6:0] OP_R = 7'b0110011;
    localparam logic [6:0] OP_I = 7'b0010011;

    localparam logic [1:0] ALU_OP_NONE = 2'b00;
    localparam logic [1:0] ALU_OP_R    = 2'b10;
    localparam logic [1:0] ALU_OP_I    = 2'b11;

    // ALUOp that belongs to a latched instruction class.
    function automatic logic [1:0] alu_op_of(input op_class_t cls);
        case (cls)
            CLS_R:   alu_op_of = ALU_OP_R;
            CLS_I:   alu_op_of = ALU_OP_I;
            default: alu_op_of = ALU_OP_NONE;
        endcase
    endfunction

    // Only the immediate class takes operand 2 from the sign-extended immediate.
    function automatic logic alu_src_of(input op_class_t cls);
        alu_src_of = (cls == CLS_I);
    endfunction

endpackage

// File: rtl/multicycle_control.sv
// multicycle_control
// Control FSM for a multicycle datapath: IDLE -> FETCH -> DECODE -> EXEC -> WB,
// with an absorbing HALT state entered on an illegal opcode or a fetch timeout.
// Build option: define PERF_CNT_EN to build the retired-instruction counter;
// without it retired_o is tied to zero.
//
// Ports
//   clk_i       clock, all state changes on the rising edge
//   rst_i       synchronous active-high reset
//   start_i     run enable (level)
//   opcode_i    instruction bits [6:0], valid from DECODE onward
//   imem_ack_i  instruction memory data valid
//   imem_req_o  fetch request, high throughout FETCH
//   ir_we_o     instruction register load, the FETCH cycle that sees ack
//   pc_we_o     PC <= PC+4 strobe, the WB cycle
//   reg_write_o register file write enable, the WB cycle
//   alu_src_o   operand-2 select (1 = immediate), EXEC and WB only
//   alu_op_o    ALUOp, EXEC and WB only
//   busy_o      high in every state except IDLE and HALT
//   fault_o     0 none, 1 illegal opcode, 2 fetch timeout
//   retired_o   retired instruction count
module multicycle_control #(
    parameter int IMEM_TIMEOUT = 15
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        start_i,
    input  logic [6:0]  opcode_i,
    input  logic        imem_ack_i,
    output logic        imem_req_o,
    output logic        ir_we_o,
    output logic        pc_we_o,
    output logic        reg_write_o,
    output logic        alu_src_o,
    output logic [1:0]  alu_op_o,
    output logic        busy_o,
    output logic [1:0]  fault_o,
    output logic [31:0] retired_o
);

    import multicycle_control_pkg::*;

    // The counter holds the number of ack-less FETCH cycles already spent, so
    // the cycle that would make it reach IMEM_TIMEOUT is the one where it
    // still reads IMEM_TIMEOUT-1.
    localparam logic [7:0] WAIT_LIMIT = 8'(IMEM_TIMEOUT - 1);

    state_t    state, next_state;
    fault_t    fault, next_fault;
    op_class_t cls, next_cls;
    logic [7:0] wait_cnt, next_wait;

    logic       imem_req_q;
    logic       pc_we_q;
    logic       reg_write_q;
    logic       alu_src_q;
    logic [1:0] alu_op_q;
    logic       busy_q;

    // Next-state logic. An ack always wins over the timeout, even when it
    // arrives in the very cycle the wait counter would expire.
    always_comb begin
        next_state = state;
        next_fault = fault;
        next_cls   = cls;
        next_wait  = wait_cnt;
        case (state)
            ST_IDLE: begin
                if (start_i) begin
                    next_state = ST_FETCH;
                    next_wait  = '0;
                end
            end
            ST_FETCH: begin
                if (imem_ack_i) begin
                    next_state = ST_DECODE;
                end else if (wait_cnt == WAIT_LIMIT) begin
                    next_state = ST_HALT;
                    next_fault = FAULT_TIMEOUT;
                end else begin
                    next_wait = wait_cnt + 8'd1;
                end
            end
            ST_DECODE: begin
                if (opcode_i == OP_R) begin
                    next_cls   = CLS_R;
                    next_state = ST_EXEC;
                end else if (opcode_i == OP_I) begin
                    next_cls   = CLS_I;
                    next_state = ST_EXEC;
                end else begin
                    next_cls   = CLS_NONE;
                    next_state = ST_HALT;
                    next_fault = FAULT_ILLEGAL;
                end
            end
            ST_EXEC: begin
                next_state = ST_WB;
            end
            ST_WB: begin
                // start_i is only consulted here, so dropping it mid-instruction
                // lets the instruction finish before returning to IDLE.
                if (start_i) begin
                    next_state = ST_FETCH;
                    next_wait  = '0;
                end else begin
                    next_state = ST_IDLE;
                end
            end
            ST_HALT: begin
                next_state = ST_HALT;
            end
            default: begin
                next_state = ST_IDLE;
            end
        endcase
    end

    // State and registered outputs. Outputs are computed from the state being
    // entered so that they line up cycle-for-cycle with the state register.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state       <= ST_IDLE;
            fault       <= FAULT_NONE;
            cls         <= CLS_NONE;
            wait_cnt    <= '0;
            imem_req_q  <= 1'b0;
            pc_we_q     <= 1'b0;
            reg_write_q <= 1'b0;
            alu_src_q   <= 1'b0;
            alu_op_q    <= ALU_OP_NONE;
            busy_q      <= 1'b0;
        end else begin
            state       <= next_state;
            fault       <= next_fault;
            cls         <= next_cls;
            wait_cnt    <= next_wait;
            imem_req_q  <= (next_state == ST_FETCH);
            pc_we_q     <= (next_state == ST_WB);
            reg_write_q <= (next_state == ST_WB);
            if ((next_state == ST_EXEC) || (next_state == ST_WB)) begin
                alu_src_q <= alu_src_of(next_cls);
                alu_op_q  <= alu_op_of(next_cls);
            end else begin
                alu_src_q <= 1'b0;
                alu_op_q  <= ALU_OP_NONE;
            end
            busy_q      <= (next_state != ST_IDLE) && (next_state != ST_HALT);
        end
    end

    // The IR load has to coincide with the ack itself, so it cannot be
    // registered; reset suppresses it so no strobe escapes during reset.
    assign ir_we_o     = (state == ST_FETCH) && imem_ack_i && !rst_i;
    assign imem_req_o  = imem_req_q;
    assign pc_we_o     = pc_we_q;
    assign reg_write_o = reg_write_q;
    assign alu_src_o   = alu_src_q;
    assign alu_op_o    = alu_op_q;
    assign busy_o      = busy_q;
    assign fault_o     = fault;

`ifdef PERF_CNT_EN
    logic [31:0] retired_q;

    // One increment per WB cycle; wraps naturally at 32 bits.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            retired_q <= '0;
        end else if (state == ST_WB) begin
            retired_q <= retired_q + 32'd1;
        end
    end

    assign retired_o = retired_q;
`else
    assign retired_o = '0;
`endif

endmodule

// File: tb/tb_multicycle_control.sv
// tb_multicycle_control
// Self-checking bench for multicycle_control. Expected output rows are built
// per instruction from its ack delay and opcode: (delay+1) FETCH cycles, then
// DECODE, EXEC, WB, or a HALT with the matching fault code.
module tb_multicycle_control;

    localparam int T = 15;
    localparam logic [6:0] OPC_R   = 7'b0110011;
    localparam logic [6:0] OPC_I   = 7'b0010011;
    localparam logic [6:0] OPC_BAD = 7'b0000011;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        start_i;
    logic [6:0]  opcode_i;
    logic        imem_ack_i;
    logic        imem_req_o;
    logic        ir_we_o;
    logic        pc_we_o;
    logic        reg_write_o;
    logic        alu_src_o;
    logic [1:0]  alu_op_o;
    logic        busy_o;
    logic [1:0]  fault_o;
    logic [31:0] retired_o;

    int          compared   = 0;
    int          mismatched = 0;
    logic [31:0] retired_model = 32'd0;
    bit          perf_en;

    multicycle_control #(.IMEM_TIMEOUT(T)) dut (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .start_i     (start_i),
        .opcode_i    (opcode_i),
        .imem_ack_i  (imem_ack_i),
        .imem_req_o  (imem_req_o),
        .ir_we_o     (ir_we_o),
        .pc_we_o     (pc_we_o),
        .reg_write_o (reg_write_o),
        .alu_src_o   (alu_src_o),
        .alu_op_o    (alu_op_o),
        .busy_o      (busy_o),
        .fault_o     (fault_o),
        .retired_o   (retired_o)
    );

    always #5 clk_i = ~clk_i;

    // Row order: req, ir_we, pc_we, reg_write, alu_src, alu_op[1:0], busy, fault[1:0]
    function automatic logic [9:0] row(input bit req, input bit irwe, input bit pcwe,
                                       input bit regw, input bit src, input logic [1:0] aop,
                                       input bit busy, input logic [1:0] flt);
        row = {req, irwe, pcwe, regw, src, aop, busy, flt};
    endfunction

    // Drive one cycle's inputs just after the rising edge and leave time to settle.
    task automatic applyStimulus(input logic rst, input logic start, input logic ack,
                                 input logic [6:0] op);
        @(posedge clk_i);
        #1;
        rst_i      = rst;
        start_i    = start;
        imem_ack_i = ack;
        opcode_i   = op;
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [9:0] expv);
        logic [9:0]  obs;
        logic [31:0] exp_ret;
        obs = {imem_req_o, ir_we_o, pc_we_o, reg_write_o, alu_src_o, alu_op_o, busy_o, fault_o};
        exp_ret = perf_en ? retired_model : 32'd0;
        compared++;
        assert (obs === expv) else begin
            mismatched++;
            $error("[TB] FAIL %s: observed %b expected %b", tag, obs, expv);
        end
        compared++;
        assert (retired_o === exp_ret) else begin
            mismatched++;
            $error("[TB] FAIL %s_retired: observed %0d expected %0d", tag, retired_o, exp_ret);
        end
    endtask

    task automatic checkValue(input string tag, input int obs, input int expv);
        compared++;
        assert (obs === expv) else begin
            mismatched++;
            $error("[TB] FAIL %s: observed %0d expected %0d", tag, obs, expv);
        end
    endtask

    task automatic doReset();
        applyStimulus(1'b1, 1'b1, 1'b1, OPC_R);
        retired_model = 32'd0;
        applyStimulus(1'b0, 1'b0, 1'b0, OPC_R);
        checkOutput("reset", row(0, 0, 0, 0, 0, 2'b00, 0, 2'd0));
    endtask

    task automatic idleStep(input bit start);
        applyStimulus(1'b0, start, 1'b0, OPC_R);
        checkOutput("idle", row(0, 0, 0, 0, 0, 2'b00, 0, 2'd0));
    endtask

    // HALT ignores every input and holds the fault code.
    task automatic haltCheck(input logic [1:0] flt);
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'b0, 1'b1, 1'b1, OPC_R);
            checkOutput("halt", row(0, 0, 0, 0, 0, 2'b00, 0, flt));
        end
    endtask

    // One instruction starting at its first FETCH cycle; ack arrives after
    // 'delay' ack-less cycles.
    task automatic runInstr(input int delay, input logic [6:0] op,
                            input bit start_exec, input bit start_wb);
        bit         acked;
        bit         legal;
        bit         src;
        logic [1:0] aop;
        int         busy_seen;
        legal     = (op == OPC_R) || (op == OPC_I);
        src       = (op == OPC_I);
        aop       = (op == OPC_R) ? 2'b10 : 2'b11;
        acked     = 1'b0;
        busy_seen = 0;
        for (int k = 1; k <= T && !acked; k++) begin
            acked = (k == delay + 1);
            applyStimulus(1'b0, 1'b1, acked, op);
            busy_seen += int'(busy_o);
            checkOutput($sformatf("fetch%0d", k), row(1, acked, 0, 0, 0, 2'b00, 1, 2'd0));
        end
        if (!acked) begin
            haltCheck(2'd2);
            return;
        end
        applyStimulus(1'b0, 1'b1, 1'b0, op);
        busy_seen += int'(busy_o);
        checkOutput("decode", row(0, 0, 0, 0, 0, 2'b00, 1, 2'd0));
        if (!legal) begin
            haltCheck(2'd1);
            return;
        end
        applyStimulus(1'b0, start_exec, 1'b0, op);
        busy_seen += int'(busy_o);
        checkOutput("exec", row(0, 0, 0, 0, src, aop, 1, 2'd0));
        applyStimulus(1'b0, start_wb, 1'b0, op);
        busy_seen += int'(busy_o);
        checkOutput("wb", row(0, 0, 1, 1, src, aop, 1, 2'd0));
        retired_model = retired_model + 32'd1;
        checkValue("latency", busy_seen, delay + 4);
    endtask

    initial begin
`ifdef PERF_CNT_EN
        perf_en = 1'b1;
`else
        perf_en = 1'b0;
`endif
        rst_i      = 1'b1;
        start_i    = 1'b0;
        imem_ack_i = 1'b0;
        opcode_i   = 7'd0;

        doReset();
        idleStep(1'b0);
        idleStep(1'b1);

        // R-type, ack in first FETCH cycle, stop afterwards.
        runInstr(0, OPC_R, 1'b1, 1'b0);
        idleStep(1'b1);

        // I-type with three wait cycles, chained into the next instruction.
        runInstr(3, OPC_I, 1'b1, 1'b1);

        // start dropped during EXEC: WB still completes, then IDLE.
        runInstr(1, OPC_R, 1'b0, 1'b0);
        idleStep(1'b0);
        idleStep(1'b1);

        // Randomized legal instruction stream.
        for (int n = 0; n < 25; n++) begin
            int         d;
            logic [6:0] op;
            bit         s_exec;
            bit         s_wb;
            d      = int'($urandom_range(0, 6));
            op     = ($urandom_range(0, 1) == 0) ? OPC_R : OPC_I;
            s_exec = ($urandom_range(0, 1) == 1);
            s_wb   = ($urandom_range(0, 2) != 0);
            runInstr(d, op, s_exec, s_wb);
            if (!s_wb) begin
                for (int g = 0; g < int'($urandom_range(0, 2)); g++) idleStep(1'b0);
                idleStep(1'b1);
            end
        end

        // Illegal opcode halts with fault 1; reset clears it.
        runInstr(2, OPC_BAD, 1'b1, 1'b1);
        doReset();
        idleStep(1'b1);

        // No ack for T cycles: timeout fault.
        runInstr(T, OPC_R, 1'b1, 1'b1);
        doReset();
        idleStep(1'b1);

        // Ack in the final allowed cycle wins over the timeout.
        runInstr(T - 1, OPC_I, 1'b1, 1'b0);
        idleStep(1'b1);

        // Reset in mid-FETCH with ack asserted must not reach DECODE.
        applyStimulus(1'b0, 1'b1, 1'b0, OPC_R);
        checkOutput("prefetch", row(1, 0, 0, 0, 0, 2'b00, 1, 2'd0));
        applyStimulus(1'b1, 1'b1, 1'b1, OPC_R);
        compared++;
        assert (ir_we_o === 1'b0) else begin
            mismatched++;
            $error("[TB] FAIL rst_irwe: observed %b expected 0", ir_we_o);
        end
        retired_model = 32'd0;
        applyStimulus(1'b0, 1'b0, 1'b1, OPC_R);
        checkOutput("rst_fetch", row(0, 0, 0, 0, 0, 2'b00, 0, 2'd0));
        idleStep(1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/multicycle_control.md
MULTICYCLE_CONTROL -- requirements
Module: multicycle_control

Interface
REQ-001 SHALL have parameter IMEM_TIMEOUT, default 15: maximum wait cycles in FETCH for imem_ack_i before a timeout fault is raised (range 1..255).
REQ-002 SHALL have port clk_i, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst_i, input, 1 bit: reset, synchronous and active-high.
REQ-004 SHALL have port start_i, input, 1 bit: run enable, level-sensitive.
REQ-005 SHALL have port opcode_i, input, 7 bits: instruction register bits [6:0], valid from DECODE onward.
REQ-006 SHALL have port imem_ack_i, input, 1 bit: instruction memory data valid.
REQ-007 SHALL have port imem_req_o, output, 1 bit: instruction fetch request.
REQ-008 SHALL have port ir_we_o, output, 1 bit: instruction register load strobe.
REQ-009 SHALL have port pc_we_o, output, 1 bit: PC update strobe (PC <= PC+4).
REQ-010 SHALL have port reg_write_o, output, 1 bit: register file write enable.
REQ-011 SHALL have port alu_src_o, output, 1 bit: ALU operand-2 select, 1 = sign-extended immediate.
REQ-012 SHALL have port alu_op_o, output, 2 bits: ALUOp to the ALU control decoder.
REQ-013 SHALL have port busy_o, output, 1 bit: high in every state except IDLE and HALT.
REQ-014 SHALL have port fault_o, output, 2 bits: 0 = none, 1 = illegal opcode, 2 = fetch timeout.
REQ-015 SHALL have port retired_o, output, 32 bits: count of retired instructions.

Function
REQ-016 SHALL implement the states IDLE, FETCH, DECODE, EXEC, WB and HALT.
REQ-017 IDLE SHALL move to FETCH on the first edge with start_i=1 and SHALL otherwise stay in IDLE.
REQ-018 FETCH SHALL hold imem_req_o=1, SHALL pulse ir_we_o=1 combinationally in the cycle imem_ack_i=1, and SHALL move to DECODE on that edge.
REQ-019 A wait counter SHALL clear on FETCH entry and increment each FETCH cycle without ack; reaching IMEM_TIMEOUT without ack SHALL move to HALT with fault_o=2.
REQ-020 An ack arriving in the same cycle the counter reaches IMEM_TIMEOUT SHALL win (normal DECODE, no fault).
REQ-021 DECODE SHALL latch the opcode class: 0110011 -> R (alu_src 0, alu_op 2'b10); 0010011 -> I (alu_src 1, alu_op 2'b11); any other value -> HALT with fault_o=1.
REQ-022 alu_src_o and alu_op_o SHALL come from the latched class and SHALL stay stable from EXEC through WB; they SHALL be 0 in all other states.
REQ-023 EXEC SHALL last exactly one cycle and move to WB.
REQ-024 WB SHALL last exactly one cycle, asserting reg_write_o=1 and pc_we_o=1 for that single cycle only.
REQ-025 From WB the block SHALL go to FETCH if start_i=1 and to IDLE if start_i=0; start_i dropping earlier SHALL not abort the instruction in flight.
REQ-026 Per-instruction latency SHALL be the FETCH cycles up to and including the ack cycle, plus 3 cycles.
REQ-027 HALT SHALL be absorbing: all strobes 0 and fault_o held until reset.

Reset
REQ-028 rst_i=1 SHALL force IDLE, zero the wait counter, latched class, fault_o and retired_o, and drive all strobes to 0; it SHALL take precedence from any state, including mid-FETCH with ack asserted.

Configuration
REQ-029 With PERF_CNT_EN defined, retired_o SHALL increment by 1 on each WB cycle and wrap from 0xFFFFFFFF to 0; without the macro, retired_o SHALL be constant 0 and no counter SHALL be built.

Structure
REQ-030 A shared package SHALL hold the state enum, the fault codes, the opcode constants OP_R=7'b0110011 and OP_I=7'b0010011, and the ALUOp codes.
REQ-031 The block SHALL be a single module with no sub-modules; the optional counter SHALL be inline under the macro.

Verification
REQ-032 Reset, then start_i=1, ack in the first FETCH cycle, opcode 0110011: the sequence is FETCH, DECODE, EXEC, WB (4 cycles); in WB reg_write_o=1, pc_we_o=1, alu_op_o=2'b10, alu_src_o=0.
REQ-033 Opcode 0010011 with ack after 3 wait cycles: ir_we_o pulses in the 4th FETCH cycle; alu_src_o=1 and alu_op_o=2'b11 in EXEC and WB; latency is 7 cycles.
REQ-034 Opcode 0000011: HALT, fault_o=1, no reg_write_o pulse; rst_i pulse returns to IDLE with fault_o=0.
REQ-035 No ack for 15 cycles with IMEM_TIMEOUT=15: HALT, fault_o=2; repeat with ack on cycle 15: no fault.
REQ-036 start_i dropped during EXEC: WB still completes and the block reaches IDLE; with PERF_CNT_EN, preload retired_o to 0xFFFFFFFF and one WB gives 0.
